// File: rtl/disp_pkg.sv
// Shared constants and load-FSM encoding for the multiplexed display scan blocks.
package disp_pkg;
  localparam int N_DIGITS = 4;
  localparam int SEL_W    = 2;
  localparam int NIB_W    = 4;
  localparam int DATA_W   = N_DIGITS * NIB_W;

  typedef enum logic {
    LD_IDLE = 1'b0,
    LD_PEND = 1'b1
  } ld_state_t;
endpackage

// File: rtl/disp_mux_scan_tick_gen.sv
// Prescaler: TICK is high for one cycle out of every PRESCALE, aligned with count == PRESCALE-1.
module tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic CLK,
  input  logic RST,
  output logic TICK
);
  localparam int               CNT_W        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST         = CNT_W'(PRESCALE - 1);
  localparam logic             TICK_AT_ZERO = (PRESCALE == 1) ? 1'b1 : 1'b0;

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             tick_r;

  assign cnt_inc_s = cnt_r + CNT_W'(1);

  // Counter with tick decoded one cycle early so TICK comes straight from a flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_r  <= '0;
      tick_r <= TICK_AT_ZERO;
    end else if (tick_r) begin
      cnt_r  <= '0;
      tick_r <= TICK_AT_ZERO;
    end else begin
      cnt_r  <= cnt_inc_s;
      tick_r <= (cnt_inc_s == LAST);
    end
  end

  assign TICK = tick_r;
endmodule

// File: rtl/disp_mux_scan.sv
// 4-digit display scan controller: digit select, digit nibble, leading-zero blank and a
// double-buffered load that only swaps the displayed value on a frame boundary.
module disp_mux_scan
  import disp_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              LD,
  output logic              LD_ACK,
  input  logic              BLANK_LZ,
  output logic [SEL_W-1:0]  SEL,
  output logic [NIB_W-1:0]  DIGIT,
  output logic              BLANK,
  output logic              FRAME_DONE
);
  logic              tick_s;
  logic              fb_s;
  logic [SEL_W-1:0]  sel_r;
  logic [DATA_W-1:0] disp_r;
  logic [DATA_W-1:0] shadow_r;
  ld_state_t         state_r;
  logic              ld_ack_r;
  logic              frame_done_r;
  logic [N_DIGITS-1:0] lz_s;
  logic [NIB_W-1:0]  digit_s;
  logic              blank_s;
  logic              acc_s;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .TICK (tick_s)
  );

  assign fb_s = tick_s & (sel_r == SEL_W'(N_DIGITS - 1));

  // Digit select counter, frame pulse and load handshake state machine.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_r        <= '0;
      disp_r       <= '0;
      shadow_r     <= '0;
      state_r      <= LD_IDLE;
      ld_ack_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      if (tick_s) begin
        sel_r <= sel_r + SEL_W'(1);
      end else begin
        sel_r <= sel_r;
      end
      frame_done_r <= fb_s;

      case (state_r)
        LD_PEND: begin
          // Transfer uses the shadow value from before this edge, even if LD reloads it now.
          if (fb_s) begin
            disp_r   <= shadow_r;
            ld_ack_r <= 1'b1;
          end else begin
            ld_ack_r <= 1'b0;
          end
          if (LD) begin
            shadow_r <= DATA_IN;
            state_r  <= LD_PEND;
          end else if (fb_s) begin
            state_r  <= LD_IDLE;
          end else begin
            state_r  <= LD_PEND;
          end
        end
        LD_IDLE: begin
          ld_ack_r <= 1'b0;
          if (LD) begin
            shadow_r <= DATA_IN;
            state_r  <= LD_PEND;
          end else begin
            state_r  <= LD_IDLE;
          end
        end
        default: begin
          ld_ack_r <= 1'b0;
          state_r  <= LD_IDLE;
        end
      endcase
    end
  end

  // Digit mux and leading-zero blanking; lz_s[i] means all nibbles at index >= i are zero.
  always_comb begin
    digit_s = disp_r[NIB_W*sel_r +: NIB_W];
    lz_s    = '0;
    acc_s   = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      acc_s   = acc_s & (disp_r[NIB_W*i +: NIB_W] == 4'd0);
      lz_s[i] = acc_s;
    end
    if (BLANK_LZ && (sel_r != 2'd0)) begin
      blank_s = lz_s[sel_r];
    end else begin
      blank_s = 1'b0;
    end
  end

  assign SEL        = sel_r;
  assign DIGIT      = digit_s;
  assign BLANK      = blank_s;
  assign LD_ACK     = ld_ack_r;
  assign FRAME_DONE = frame_done_r;
endmodule

// File: tb/tb_disp_mux_scan.sv
// Bench for disp_mux_scan: PRESCALE=4 and PRESCALE=1 instances on shared stimulus, a
// cycle-count reference model, a hand-derived vector table and targeted handshake sequences.
module tb_disp_mux_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld = 1'b0;
  logic        blz = 1'b0;
  logic [15:0] data = 16'h0000;

  logic [1:0] sel4, sel1;
  logic [3:0] dig4, dig1;
  logic       bl4, bl1, fd4, fd1, ack4, ack1;

  always #5 clk = ~clk;

  disp_mux_scan #(.PRESCALE(4)) dut4 (
    .CLK(clk), .RST(rst), .DATA_IN(data), .LD(ld), .LD_ACK(ack4), .BLANK_LZ(blz),
    .SEL(sel4), .DIGIT(dig4), .BLANK(bl4), .FRAME_DONE(fd4));

  disp_mux_scan #(.PRESCALE(1)) dut1 (
    .CLK(clk), .RST(rst), .DATA_IN(data), .LD(ld), .LD_ACK(ack1), .BLANK_LZ(blz),
    .SEL(sel1), .DIGIT(dig1), .BLANK(bl1), .FRAME_DONE(fd1));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: position in the scan derived from edges since reset.
  int          m_p[2] = '{4, 1};
  int          m_n[2];
  bit          m_pend[2];
  logic [15:0] m_shadow[2];
  logic [15:0] m_disp[2];
  bit          m_ack[2];
  bit          m_fd[2];

  typedef struct {
    int          cyc;
    logic        rst;
    logic        ld;
    logic [15:0] data;
    logic        blz;
    int          sel;
    int          dig;
    int          blank;
    int          fd;
    int          ack;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input int i);
    bit fb;
    if (rst) begin
      m_n[i] = 0; m_pend[i] = 0; m_shadow[i] = 16'h0000; m_disp[i] = 16'h0000;
      m_ack[i] = 0; m_fd[i] = 0;
    end else begin
      fb = ((m_n[i] % (4 * m_p[i])) == (4 * m_p[i] - 1));
      m_fd[i]  = fb;
      m_ack[i] = fb && m_pend[i];
      if (fb && m_pend[i]) m_disp[i] = m_shadow[i];
      if (ld) begin
        m_shadow[i] = data;
        m_pend[i]   = 1;
      end else if (fb) begin
        m_pend[i] = 0;
      end
      m_n[i]++;
    end
  endtask

  task automatic check_model();
    int s, d, b;
    int a_sel, a_dig, a_bl, a_fd, a_ack;
    for (int i = 0; i < 2; i++) begin
      s = (m_n[i] / m_p[i]) % 4;
      d = int'((m_disp[i] >> (4 * s)) & 16'h000F);
      b = (blz && s != 0 && ((m_disp[i] >> (4 * s)) == 16'h0000)) ? 1 : 0;
      if (i == 0) begin
        a_sel = sel4; a_dig = dig4; a_bl = bl4; a_fd = fd4; a_ack = ack4;
      end else begin
        a_sel = sel1; a_dig = dig1; a_bl = bl1; a_fd = fd1; a_ack = ack1;
      end
      check($sformatf("model_sel[p%0d]", m_p[i]),   a_sel, s);
      check($sformatf("model_digit[p%0d]", m_p[i]), a_dig, d);
      check($sformatf("model_blank[p%0d]", m_p[i]), a_bl,  b);
      check($sformatf("model_fd[p%0d]", m_p[i]),    a_fd,  int'(m_fd[i]));
      check($sformatf("model_ack[p%0d]", m_p[i]),   a_ack, int'(m_ack[i]));
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [15:0] d, input logic b);
    rst = r; ld = l; data = d; blz = b;
    @(posedge clk);
    #1;
    model_edge(0);
    model_edge(1);
    check_model();
  endtask

  function automatic void add(input int cyc, input logic r, input logic l, input logic [15:0] d,
                              input logic b, input int s, input int dg, input int bk,
                              input int f, input int a);
    vec_t v;
    v.cyc = cyc; v.rst = r; v.ld = l; v.data = d; v.blz = b;
    v.sel = s; v.dig = dg; v.blank = bk; v.fd = f; v.ack = a;
    tbl.push_back(v);
  endfunction

  initial begin
    int acks, seen, bad, lat, guard;

    // PRESCALE=4 expectations; comment gives edges since reset after each row.
    add(1, 1, 0, 16'h0000, 0, 0, 0, 0, 0, 0);  // k=0
    add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);  // k=1
    add(3, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0);  // k=4
    add(3, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0);  // k=7
    add(1, 0, 0, 16'h0000, 0, 2, 0, 0, 0, 0);  // k=8
    add(4, 0, 0, 16'h0000, 0, 3, 0, 0, 0, 0);  // k=12
    add(3, 0, 0, 16'h0000, 0, 3, 0, 0, 0, 0);  // k=15
    add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0);  // k=16 wrap
    add(1, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0);  // k=17
    add(3, 0, 0, 16'h0000, 0, 1, 0, 0, 0, 0);  // k=20
    add(1, 0, 1, 16'h1234, 0, 1, 0, 0, 0, 0);  // k=21 load at SEL=1
    add(10, 0, 0, 16'h0000, 0, 3, 0, 0, 0, 0); // k=31
    add(1, 0, 0, 16'h0000, 0, 0, 4, 0, 1, 1);  // k=32 transfer
    add(1, 0, 0, 16'h0000, 0, 0, 4, 0, 0, 0);  // k=33
    add(3, 0, 0, 16'h0000, 0, 1, 3, 0, 0, 0);  // k=36
    add(4, 0, 0, 16'h0000, 0, 2, 2, 0, 0, 0);  // k=40
    add(4, 0, 0, 16'h0000, 0, 3, 1, 0, 0, 0);  // k=44
    add(1, 0, 1, 16'h0050, 0, 3, 1, 0, 0, 0);  // k=45
    add(3, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 1);  // k=48 shows 0050
    add(4, 0, 0, 16'h0000, 1, 1, 5, 0, 0, 0);  // k=52
    add(4, 0, 0, 16'h0000, 1, 2, 0, 1, 0, 0);  // k=56
    add(4, 0, 0, 16'h0000, 1, 3, 0, 1, 0, 0);  // k=60
    add(4, 0, 0, 16'h0000, 0, 0, 0, 0, 1, 0);  // k=64 idle fb
    add(4, 0, 0, 16'h0000, 0, 1, 5, 0, 0, 0);  // k=68
    add(4, 0, 0, 16'h0000, 0, 2, 0, 0, 0, 0);  // k=72 no blank with BLANK_LZ=0
    add(1, 0, 1, 16'h0000, 0, 2, 0, 0, 0, 0);  // k=73
    add(7, 0, 0, 16'h0000, 1, 0, 0, 0, 1, 1);  // k=80 shows 0000
    add(4, 0, 0, 16'h0000, 1, 1, 0, 1, 0, 0);  // k=84

    foreach (tbl[r]) begin
      step(tbl[r].rst, tbl[r].ld, tbl[r].data, tbl[r].blz);
      for (int c = 1; c < tbl[r].cyc; c++) step(1'b0, 1'b0, 16'h0000, tbl[r].blz);
      check($sformatf("tbl[%0d].sel", r),   sel4, tbl[r].sel);
      check($sformatf("tbl[%0d].digit", r), dig4, tbl[r].dig);
      check($sformatf("tbl[%0d].blank", r), bl4,  tbl[r].blank);
      check($sformatf("tbl[%0d].fd", r),    fd4,  tbl[r].fd);
      check($sformatf("tbl[%0d].ack", r),   ack4, tbl[r].ack);
    end

    // Two loads before one boundary: one ack, last value wins.
    step(1'b0, 1'b1, 16'h1111, 1'b0);
    step(1'b0, 1'b1, 16'h2222, 1'b0);
    acks = 0; seen = 0;
    for (int c = 0; c < 32 && seen == 0; c++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      if (ack4) acks++;
      if (fd4) seen = 1;
    end
    check("t3_fd_seen", seen, 1);
    check("t3_single_ack", acks, 1);
    check("t3_digit0", dig4, 2);

    // Load exactly on the boundary edge while pending.
    step(1'b0, 1'b1, 16'h2222, 1'b0);
    guard = 0;
    while ((m_n[0] % 16) != 15 && guard < 20) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      guard++;
    end
    check("t3_reach_fb", guard < 20 ? 1 : 0, 1);
    step(1'b0, 1'b1, 16'hABCD, 1'b0);
    check("t3_fb_ack", ack4, 1);
    check("t3_fb_fd", fd4, 1);
    check("t3_fb_digit", dig4, 2);
    acks = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      if (ack4) acks++;
    end
    check("t3_second_ack", acks, 1);
    check("t3_abcd_digit0", dig4, 13);

    // Reset discards a pending load.
    step(1'b0, 1'b1, 16'h9999, 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    check("t5_sel", sel4, 0);
    check("t5_digit", dig4, 0);
    acks = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b0, 16'h0000, 1'b0);
      if (ack4 || ack1) acks++;
      if (dig4 != 4'd0 || dig1 != 4'd0) bad++;
    end
    check("t5_no_ack", acks, 0);
    check("t5_digit_zero", bad, 0);

    // PRESCALE=1: a load is acked within four cycles.
    step(1'b0, 1'b1, 16'h4321, 1'b0);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      if (ack1) lat = c;
      else step(1'b0, 1'b0, 16'h0000, 1'b0);
    end
    check("t6_ack_within_4", (lat >= 1 && lat <= 4) ? 1 : 0, 1);
    check("t6_digit", dig1, 1);

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(63) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(7) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(3) == 0) ? 16'($urandom_range(255)) : 16'($urandom),
           1'($urandom_range(1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/disp_mux_scan.md
Name: disp_mux_scan

Overview:
Upstream scan controller for the 4-digit multiplexed 7-segment display. It produces the 2-bit digit select that drives the 2:4 one-hot anode decoder, the matching 4-bit digit nibble for the segment decoder, and a blank flag. A load handshake double-buffers the displayed value so updates take effect only at a frame boundary, which prevents a frame mixing old and new digits.

Parameters:
PRESCALE, 50000, CLK cycles per digit slot; legal range >= 1.

Ports:
CLK  in  1  system clock; all state updates on the rising edge.
RST  in  1  synchronous, active-high reset.
DATA_IN  in  16  four nibbles; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
LD  in  1  load request; DATA_IN is sampled on any cycle where LD=1.
LD_ACK  out  1  one-cycle pulse when a pending value is transferred to the display register.
BLANK_LZ  in  1  enables leading-zero blanking.
SEL  out  2  current digit index; feeds the anode decoder.
DIGIT  out  4  nibble of the display register selected by SEL.
BLANK  out  1  1 = current digit is blanked (segment stage drives all segments off).
FRAME_DONE  out  1  one-cycle pulse on the SEL 3->0 wrap.

Behaviour:
- Reset (RST=1 at an edge): prescaler=0, SEL=0, disp_reg=0, shadow=0, state=IDLE, LD_ACK=0, FRAME_DONE=0. A pending load is discarded and no ack is issued. RST has priority over every other input.
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. tick=1 on the cycle where count==PRESCALE-1. With PRESCALE=1, tick=1 every cycle.
- SEL: on tick, SEL <= SEL+1 mod 4. SEL holds between ticks, so each digit is shown for exactly PRESCALE cycles.
- Frame boundary (fb) = tick AND SEL==3. FRAME_DONE is registered and equals 1 for the single cycle after the fb edge, i.e. the same cycle in which SEL becomes 0.
- Load FSM, states IDLE and PENDING:
  - LD=1 in any state: shadow <= DATA_IN; state <= PENDING. The latest LD wins.
  - fb in PENDING: disp_reg <= shadow (the value held before this edge); LD_ACK=1 for the following cycle.
  - If LD=1 coincides with fb in PENDING: the old shadow is transferred and acked, the new DATA_IN goes to shadow, and state stays PENDING, so a second ack follows at the next fb.
  - fb with no LD in PENDING: state <= IDLE.
  - fb in IDLE: no transfer and no ack.
  - Each transfer produces exactly one ack, regardless of how many LDs preceded it.
- DIGIT: combinational, disp_reg[4*SEL +: 4]. Zero latency from SEL and disp_reg.
- BLANK: combinational. BLANK=1 iff BLANK_LZ=1, SEL!=0, and every nibble at index >= SEL is 0. Digit 0 is never blanked. BLANK=0 whenever BLANK_LZ=0.
- Width rules: the prescaler counter width is clog2(PRESCALE), minimum 1 bit. No arithmetic other than the counter increment and the SEL wrap.

Decomposition:
- Shared package (disp_pkg) holds:
  - constants N_DIGITS=4, SEL_W=2, NIB_W=4;
  - load FSM state encoding LD_IDLE=0, LD_PEND=1.
- One natural sub-module, tick_gen: parameter PRESCALE, ports CLK, RST, TICK. It is the prescaler, reusable by other display and debounce blocks.
- The FSM, SEL counter and digit/blank muxing stay in disp_mux_scan.

Test Plan:
1. PRESCALE=4, reset, then run 20 cycles -> SEL goes 0,1,2,3,0, each value held 4 cycles; FRAME_DONE=1 only in the cycle SEL returns to 0; LD_ACK stays 0; DIGIT=0 throughout.
2. One-cycle LD with DATA_IN=16'h1234 while SEL=1 -> DIGIT stays 0 until the wrap; LD_ACK=1 in the same cycle as FRAME_DONE; next frame DIGIT=4,3,2,1 for SEL=0,1,2,3.
3. LD 16'h1111, then LD 16'h2222 before the boundary -> exactly one LD_ACK; displayed value is 16'h2222. LD 16'hABCD on the fb cycle while pending -> ack for 16'h2222 now, a second ack one frame later, then 16'hABCD is displayed.
4. BLANK_LZ=1, displayed 16'h0050 -> BLANK=1 at SEL=3 and SEL=2; BLANK=0 at SEL=1 (DIGIT=5) and at SEL=0 (DIGIT=0). Displayed 16'h0000 -> only SEL=0 unblanked. BLANK_LZ=0 -> BLANK=0 always.
5. LD 16'h9999, then RST=1 for one cycle before the boundary -> no LD_ACK ever; SEL=0, DIGIT=0 after reset; the next fb produces no transfer.
6. PRESCALE=1 instance -> SEL increments every cycle and FRAME_DONE pulses every 4th cycle; an LD is acked within 4 cycles.
